// File: rtl/irq_pkg.sv
// irq_pkg: shared constants and mcause helper for the interrupt controller
package irq_pkg;
    localparam int N_IRQ_DEFAULT = 32;
    localparam int CAUSE_OFFSET_DEFAULT = 16;
    localparam logic [31:0] MCAUSE_IRQ_BIT = 32'h8000_0000;
    function automatic logic [31:0] cause_of(input int unsigned idx, input int unsigned offset);
        return MCAUSE_IRQ_BIT | 32'(offset + idx);
    endfunction
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set bit of pending wins
// ports: pending (requests in), grant (one-hot winner), index (winner number), valid (any pending)
module irq_prio_enc #(
    parameter int N = 32,
    parameter int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pending,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index,
    output logic          valid
);
    always_comb begin
        grant = '0;
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant = N'(1) << i;
                index = IW'(i);
            end
        end
    end
    assign valid = |pending;
endmodule

// File: rtl/irq_controller.sv
// irq_controller: masks and prioritises request lines, raises irq_o with mcause, acks source on mret
// ports: clk_i, rst_i (async, active-high), irq_req_i/mie_i (requests and enables),
//        mstatus_mie_i (global enable), exception_i, mret_i (core events),
//        irq_o (take-interrupt pulse), irq_cause_o (mcause), irq_ret_o (one-hot ack pulse)
module irq_controller
    import irq_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEFAULT,
    parameter int CAUSE_OFFSET = CAUSE_OFFSET_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [N_IRQ-1:0] mie_i,
    input  logic             mstatus_mie_i,
    input  logic             exception_i,
    input  logic             mret_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic [N_IRQ-1:0] irq_ret_o
);
    localparam int IW = N_IRQ > 1 ? $clog2(N_IRQ) : 1;
    logic             exc_h, irq_h;
    logic [N_IRQ-1:0] irq_sel_q, grant;
    logic [31:0]      cause_q, cause_now;
    logic [IW-1:0]    index;
    logic             valid;
    irq_prio_enc #(.N(N_IRQ), .IW(IW)) u_enc (
        .pending(irq_req_i & mie_i),
        .grant(grant),
        .index(index),
        .valid(valid)
    );
    assign cause_now = cause_of(32'(index), CAUSE_OFFSET);
    // rst_i gating keeps outputs quiet while reset is held, even with requests pending
    assign irq_o = ~rst_i & mstatus_mie_i & valid & ~irq_h & ~exc_h & ~exception_i;
    assign irq_cause_o = irq_o ? cause_now : irq_h ? cause_q : '0;
    // an exception in the same cycle cancels the mret, so no ack either
    assign irq_ret_o = (~rst_i & mret_i & irq_h & ~exc_h & ~exception_i) ? irq_sel_q : '0;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exc_h     <= 1'b0;
            irq_h     <= 1'b0;
            irq_sel_q <= '0;
            cause_q   <= '0;
        end else if (exception_i) begin
            exc_h <= 1'b1;
        end else if (mret_i && exc_h) begin
            exc_h <= 1'b0;
        end else if (mret_i && irq_h) begin
            irq_h     <= 1'b0;
            irq_sel_q <= '0;
            cause_q   <= '0;
        end else if (irq_o) begin
            irq_h     <= 1'b1;
            irq_sel_q <= grant;
            cause_q   <= cause_now;
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed self-checking bench for irq_controller
module tb_irq_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] req = '0;
    logic [31:0] mie = '0;
    logic        mst = 1'b0;
    logic        exc = 1'b0;
    logic        mret = 1'b0;
    logic        irq;
    logic [31:0] cause;
    logic [31:0] ret;
    int          n_cmp = 0;
    int          n_err = 0;

    irq_controller dut (
        .clk_i(clk),
        .rst_i(rst),
        .irq_req_i(req),
        .mie_i(mie),
        .mstatus_mie_i(mst),
        .exception_i(exc),
        .mret_i(mret),
        .irq_o(irq),
        .irq_cause_o(cause),
        .irq_ret_o(ret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        check("rst_irq", {31'd0, irq}, 0);
        check("rst_cause", cause, 0);
        check("rst_ret", ret, 0);
        #9 rst = 1'b0;
        step();
        // single request on line 0
        req = 32'h1; mie = 32'hffff_ffff; mst = 1'b1;
        #1;
        check("t1_irq", {31'd0, irq}, 1);
        check("t1_cause", cause, 32'h8000_0010);
        step();
        check("t1_irq_pulse", {31'd0, irq}, 0);
        check("t1_cause_held", cause, 32'h8000_0010);
        mret = 1'b1;
        #1;
        check("t1_ret", ret, 32'h1);
        step();
        mret = 1'b0; req = 32'h0;
        #1;
        check("t1_ret_pulse", ret, 0);
        check("t1_cause_clr", cause, 0);
        check("t1_irq_idle", {31'd0, irq}, 0);
        // priority: lines 2 and 4
        req = 32'h14;
        #1;
        check("t2_irq", {31'd0, irq}, 1);
        check("t2_cause", cause, 32'h8000_0012);
        step();
        req = 32'h15;
        #1;
        check("t2_cause_stable", cause, 32'h8000_0012);
        check("t2_no_reirq", {31'd0, irq}, 0);
        mret = 1'b1;
        #1;
        check("t2_ret", ret, 32'h4);
        step();
        mret = 1'b0; req = 32'h10;
        #1;
        check("t2_irq2", {31'd0, irq}, 1);
        check("t2_cause2", cause, 32'h8000_0014);
        step();
        mret = 1'b1;
        #1;
        check("t2_ret2", ret, 32'h10);
        step();
        mret = 1'b0; req = 32'h0;
        // masking of line 31
        req = 32'h8000_0000; mie = 32'h7fff_ffff;
        #1;
        check("t3_mie_mask", {31'd0, irq}, 0);
        mie = 32'hffff_ffff; mst = 1'b0;
        #1;
        check("t3_mst_mask", {31'd0, irq}, 0);
        check("t3_mask_cause", cause, 0);
        mst = 1'b1;
        #1;
        check("t3_irq", {31'd0, irq}, 1);
        check("t3_cause", cause, 32'h8000_002f);
        step();
        mret = 1'b1;
        #1;
        check("t3_ret", ret, 32'h8000_0000);
        step();
        mret = 1'b0; req = 32'h0;
        // exception beats a pending irq
        req = 32'h1; exc = 1'b1;
        #1;
        check("t4_irq_supp", {31'd0, irq}, 0);
        check("t4_cause", cause, 0);
        step();
        exc = 1'b0;
        #1;
        check("t4_exc_h_blocks", {31'd0, irq}, 0);
        mret = 1'b1;
        #1;
        check("t4_ret_none", ret, 0);
        step();
        mret = 1'b0;
        #1;
        check("t4_irq_after", {31'd0, irq}, 1);
        check("t4_cause_after", cause, 32'h8000_0010);
        step();
        mret = 1'b1;
        #1;
        check("t4_ret", ret, 32'h1);
        step();
        mret = 1'b0; req = 32'h0;
        // nested exception in ISR, with a simultaneous mret that must be cancelled
        req = 32'h1;
        #1;
        check("t5_irq", {31'd0, irq}, 1);
        step();
        exc = 1'b1; mret = 1'b1;
        #1;
        check("t5_ret_exc_wins", ret, 0);
        step();
        exc = 1'b0;
        #1;
        check("t5_ret_first", ret, 0);
        check("t5_cause_in_exc", cause, 32'h8000_0010);
        step();
        #1;
        check("t5_ret_second", ret, 32'h1);
        step();
        mret = 1'b0; req = 32'h0;
        #1;
        check("t5_cause_clr", cause, 0);
        // async reset while in handler
        req = 32'h1;
        step();
        check("t6_cause_in_isr", cause, 32'h8000_0010);
        mret = 1'b1;
        #1;
        check("t6_ret_inflight", ret, 32'h1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_irq", {31'd0, irq}, 0);
        check("t6_rst_ret", ret, 0);
        check("t6_rst_cause", cause, 0);
        mret = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("t6_fresh_irq", {31'd0, irq}, 1);
        check("t6_fresh_cause", cause, 32'h8000_0010);
        step();
        mret = 1'b1;
        #1;
        check("t6_ret", ret, 32'h1);
        step();
        mret = 1'b0; req = 32'h0;
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Priority interrupt controller between the external `int_req` lines of `riscv_unit` and the core's CSR/trap logic.
- Masks and prioritises the 32 request lines, then raises a single `irq_o` to the core with a matching mcause value.
- Tracks whether an interrupt or exception handler is in progress.
- On `mret` it emits a one-hot acknowledge back to the requesting source.

Parameters:
- N_IRQ, 32, number of request lines; index 0 has the highest priority.
- CAUSE_OFFSET, 16, mcause code for line 0; line i reports CAUSE_OFFSET+i.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- irq_req_i  in  N_IRQ  level-sensitive interrupt requests
- mie_i  in  N_IRQ  per-line enable (CSR mie contents)
- mstatus_mie_i  in  1  global interrupt enable
- exception_i  in  1  core is taking a synchronous exception this cycle
- mret_i  in  1  core is executing mret this cycle
- irq_o  out  1  take-interrupt request to the core, one-cycle pulse
- irq_cause_o  out  32  mcause value for the accepted interrupt
- irq_ret_o  out  N_IRQ  one-hot acknowledge to the serviced source, one-cycle pulse

Behaviour:
- State is two flags, exc_h (exception handler active) and irq_h (interrupt handler active), plus a latched one-hot `irq_sel_q` and `cause_q`.
- Reset (asynchronous, rst_i=1):
  - exc_h=0, irq_h=0, irq_sel_q=0, cause_q=0.
  - Outputs: irq_o=0, irq_cause_o=0, irq_ret_o=0.
- pending = irq_req_i & mie_i. grant = lowest set bit of pending, one-hot; all zeros if pending==0.
- irq_o is combinational:
  - irq_o = mstatus_mie_i & |pending & ~irq_h & ~exc_h & ~exception_i.
  - Because irq_h is set at the next edge, irq_o is high for exactly one cycle per accepted interrupt.
- On a clock edge with irq_o=1: irq_h<=1, irq_sel_q<=grant, cause_q<=32'h8000_0000 | (CAUSE_OFFSET+index(grant)).
- irq_cause_o:
  - Equals the combinational cause value in the irq_o cycle.
  - Equals cause_q while irq_h=1.
  - 0 otherwise.
- exception_i=1: exc_h<=1 at the next edge. exception_i has priority over an irq in the same cycle; irq_o is suppressed and the request remains pending (level).
- exception_i while irq_h=1 (nested fault in an ISR): exc_h<=1; irq_h is unchanged.
- mret_i handling:
  - exc_h=1: exc_h<=0; irq_ret_o stays 0.
  - exc_h=0, irq_h=1: irq_ret_o = irq_sel_q in the same cycle (combinational); at the edge irq_h<=0, irq_sel_q<=0, cause_q<=0.
  - Both flags clear: ignored, no output.
- mret_i and exception_i in the same cycle: the exception wins. exc_h<=1, and the mret clearing is not applied.
- Back-to-back interrupts: the earliest irq_o after an mret that clears irq_h is the cycle after that mret. Lines still pending are re-arbitrated at that point.
- Changes to a request line while irq_h=1 have no effect on irq_sel_q or cause_q.
- Reset mid-handler clears all state immediately; any irq_ret_o pulse in flight is dropped.
- No internal edge detection. The source must deassert its request upon seeing irq_ret_o, otherwise it re-fires.

Decomposition:
- Package irq_pkg holds:
  - N_IRQ_DEFAULT=32 and CAUSE_OFFSET_DEFAULT=16.
  - MCAUSE_IRQ_BIT=32'h8000_0000.
  - Function cause_of(idx).
- Sub-module irq_prio_enc: combinational daisy-chain/priority encoder with pending in, grant one-hot out, index out, and valid out.
- The irq_controller top holds the flags, the latches and the output logic.

Test Plan:
- Single request: irq_req_i=32'h1, mie_i=all ones, mstatus_mie_i=1 → irq_o high for 1 cycle, irq_cause_o=32'h8000_0010. Then mret_i → irq_ret_o=32'h1 for 1 cycle, and irq_cause_o returns to 0.
- Priority: irq_req_i=32'h0000_0014 → grant to line 2, cause 32'h8000_0012. After mret and a line-2 drop, a second irq_o fires for line 4 with cause 32'h8000_0014.
- Masking: irq_req_i=32'h8000_0000 with mie_i[31]=0, or with mstatus_mie_i=0 → irq_o stays 0. Setting mie_i[31]=1 → irq_o fires with cause 32'h8000_002F.
- Exception precedence: exception_i and a pending irq in the same cycle → irq_o=0, exc_h set. After mret_i, irq_ret_o=0 and irq_o fires the next cycle.
- Nested exception in ISR: irq accepted on line 0, then exception_i. First mret clears exc_h with irq_ret_o=0. Second mret gives irq_ret_o=32'h1.
- Asynchronous reset asserted while irq_h=1 (mid-cycle) → all outputs 0 immediately. After release, a held request produces a fresh irq_o.
